// File: rtl/game_pkg.sv
// Shared game_calc definitions: scroll FSM states, default screen/level geometry
// and small arithmetic helpers used by the scroll controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCROLL_L = 2'd1,
        SCROLL_R = 2'd2,
        FROZEN   = 2'd3
    } scroll_state_t;

    localparam int DEF_VIEW_W  = 640;
    localparam int DEF_WORLD_W = 1280;
    localparam int DEF_DEAD_L  = 90;
    localparam int DEF_DEAD_R  = 270;

    // Saturating increment used for the scroll acceleration
    function automatic int sat_inc(input int cur, input int lim);
        int res;
        if (cur >= lim) begin
            res = lim;
        end else begin
            res = cur + 32'sd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running rate divider: a registered one-cycle tick every DIV+1 clocks.
// Shared by the game_calc rate limiters; it never produces a derived clock.
module tick_gen #(
    parameter int DIV = 4999999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [CW-1:0] DIV_C = CW'(DIV);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Counter wraps at DIV; the wrap is registered as the tick enable
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == DIV_C) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/scroll_ctrl.sv
// Horizontal camera: follows char_X with a dead zone, accelerating tick-rate
// scrolling, clamp or wrap at the level edges, and frame-start commit of bg_pos.
module scroll_ctrl
    import game_pkg::*;
#(
    parameter int POS_W    = 11,
    parameter int TICK_DIV = 4999999,
    parameter int DEAD_L   = DEF_DEAD_L,
    parameter int DEAD_R   = DEF_DEAD_R,
    parameter int VIEW_W   = DEF_VIEW_W,
    parameter int WORLD_W  = DEF_WORLD_W,
    parameter int MAX_STEP = 4,
    parameter int WRAP_EN  = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [POS_W-1:0] char_X,
    input  logic             frame_start,
    input  logic             freeze,
    output logic [POS_W-1:0] bg_pos,
    output logic             scrolling,
    output logic             at_min,
    output logic             at_max
);

    // Two guard bits keep rel and the wrap corrections free of overflow
    localparam int RW     = POS_W + 2;
    localparam int STEP_W = $clog2(MAX_STEP + 1);

    typedef logic signed [RW-1:0] sval_t;

    localparam sval_t ZERO_S    = sval_t'(0);
    localparam sval_t WORLD_S   = sval_t'(WORLD_W);
    localparam sval_t HALF_S    = sval_t'(WORLD_W / 2);
    localparam sval_t DEAD_L_S  = sval_t'(DEAD_L);
    localparam sval_t DEAD_R_S  = sval_t'(DEAD_R);
    localparam sval_t POS_MAX_S = sval_t'(WORLD_W - VIEW_W);

    localparam logic [POS_W-1:0]  POS_MAX_P  = POS_W'(WORLD_W - VIEW_W);
    localparam logic [POS_W-1:0]  POS_ZERO   = {POS_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
    localparam logic              CLAMP_MODE = (WRAP_EN == 0);

    scroll_state_t     state_r;
    logic [STEP_W-1:0] step_r;
    logic [POS_W-1:0]  pos_next_r;
    logic [POS_W-1:0]  bg_pos_r;
    logic              scrolling_r;
    logic              at_min_r;
    logic              at_max_r;

    logic              tick_s;
    sval_t             char_s;
    sval_t             pos_s;
    sval_t             step_s;
    sval_t             rel_raw_s;
    sval_t             rel_s;
    sval_t             inc_s;
    sval_t             dec_s;
    sval_t             mv_r_s;
    sval_t             mv_l_s;
    logic              in_zone_s;
    logic              go_l_s;
    logic              go_r_s;
    logic [STEP_W-1:0] step_inc_s;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick_s)
    );

    // Distance to the character and candidate positions for both directions
    always_comb begin
        char_s    = sval_t'(char_X);
        pos_s     = sval_t'(pos_next_r);
        step_s    = sval_t'(step_r);
        rel_raw_s = char_s - pos_s;
        inc_s     = pos_s + step_s;
        dec_s     = pos_s - step_s;
        if (WRAP_EN != 0) begin
            // Shortest way round the ring decides direction
            if (rel_raw_s >= HALF_S) begin
                rel_s = rel_raw_s - WORLD_S;
            end else if (rel_raw_s < -HALF_S) begin
                rel_s = rel_raw_s + WORLD_S;
            end else begin
                rel_s = rel_raw_s;
            end
            mv_r_s = (inc_s >= WORLD_S) ? (inc_s - WORLD_S) : inc_s;
            mv_l_s = (dec_s < ZERO_S) ? (dec_s + WORLD_S) : dec_s;
        end else begin
            rel_s  = rel_raw_s;
            mv_r_s = (inc_s > POS_MAX_S) ? POS_MAX_S : inc_s;
            mv_l_s = (dec_s < ZERO_S) ? ZERO_S : dec_s;
        end
        go_l_s     = (rel_s < DEAD_L_S);
        go_r_s     = (rel_s > DEAD_R_S);
        in_zone_s  = !go_l_s && !go_r_s;
        step_inc_s = STEP_W'(sat_inc(int'(step_r), MAX_STEP));
    end

    // Scroll FSM, pending offset, frame commit and status flags
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= IDLE;
            step_r      <= STEP_ONE;
            pos_next_r  <= POS_ZERO;
            bg_pos_r    <= POS_ZERO;
            scrolling_r <= 1'b0;
            at_min_r    <= CLAMP_MODE;
            at_max_r    <= 1'b0;
        end else begin
            // Commit sees the pre-tick pos_next, freeze or not
            if (frame_start) begin
                bg_pos_r <= pos_next_r;
            end else begin
                bg_pos_r <= bg_pos_r;
            end
            scrolling_r <= (state_r == SCROLL_L) || (state_r == SCROLL_R);
            at_min_r    <= CLAMP_MODE && (bg_pos_r == POS_ZERO);
            at_max_r    <= CLAMP_MODE && (bg_pos_r == POS_MAX_P);

            if (freeze) begin
                state_r <= FROZEN;
            end else if (state_r == FROZEN) begin
                state_r <= IDLE;
                step_r  <= STEP_ONE;
            end else if (tick_s) begin
                case (state_r)
                    IDLE: begin
                        if (go_l_s) begin
                            state_r <= SCROLL_L;
                        end else if (go_r_s) begin
                            state_r <= SCROLL_R;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    SCROLL_L: begin
                        if (in_zone_s) begin
                            state_r <= IDLE;
                            step_r  <= STEP_ONE;
                        end else if (go_r_s) begin
                            state_r <= SCROLL_R;
                            step_r  <= STEP_ONE;
                        end else begin
                            pos_next_r <= POS_W'(mv_l_s);
                            step_r     <= step_inc_s;
                        end
                    end
                    SCROLL_R: begin
                        if (in_zone_s) begin
                            state_r <= IDLE;
                            step_r  <= STEP_ONE;
                        end else if (go_l_s) begin
                            state_r <= SCROLL_L;
                            step_r  <= STEP_ONE;
                        end else begin
                            pos_next_r <= POS_W'(mv_r_s);
                            step_r     <= step_inc_s;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        step_r  <= STEP_ONE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bg_pos    = bg_pos_r;
    assign scrolling = scrolling_r;
    assign at_min    = at_min_r;
    assign at_max    = at_max_r;

endmodule
